// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// slice width and the sizing helpers derived from the operand width.
package nibble_serial_adder_pkg;

    // Operation phases: waiting for operands, adding nibbles, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the single ripple-carry slice shared by every nibble.
    localparam int SLICE_W = 4;

    // Number of slice passes needed to cover the full operand width.
    function automatic int nib_count(input int width);
        return width / SLICE_W;
    endfunction

    // Nibble counter width; a single-nibble adder still needs one bit.
    function automatic int cnt_width(input int width);
        int nib;
        nib = width / SLICE_W;
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4_cin.sv
// 4-bit ripple-carry adder with carry-in, one full-adder cell per bit.
// Purely combinational; the owning block registers the carry between nibbles.
module rca4_cin
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               carry
);

    // c[i] is the carry into bit i; c[SLICE_W] leaves the slice.
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        logic p;
        logic g;
        // Propagate/generate form of a full adder.
        assign p        = a[i] ^ b[i];
        assign g        = a[i] & b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i+1]   = g | (p & c[i]);
    end

    assign carry = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit ripple slice is reused NIB times,
// low nibble first, with the inter-nibble carry held in a register.
// Optional feature macro: NIBBLE_SERIAL_ADDER_CIN_EN adds a cin port that
// seeds the carry register when operands are accepted.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               creg;
    logic [CNT_W-1:0]   cnt;

    logic               seed;
    logic               last;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_co;
    logic [WIDTH-1:0]   sum_nxt;

    // Carry seed at accept time: external carry-in when present, else zero.
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
    assign seed = cin;
`else
    assign seed = 1'b0;
`endif

    // The counter stops at NIB-1, so the terminal compare never wraps.
    assign last = (cnt == CNT_LAST);

    // Shared slice always works on the current low nibble of both operands.
    rca4_cin u_slice (
        .a     (opa[SLICE_W-1:0]),
        .b     (opb[SLICE_W-1:0]),
        .cin   (creg),
        .sum   (slice_sum),
        .carry (slice_co)
    );

    // New nibble enters at the MSB end; after NIB shifts the first nibble
    // computed has reached bits [3:0]. Written as shift/or so WIDTH == 4
    // needs no special case.
    assign sum_nxt = (sum >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the two handshake outputs taken straight from state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, shift one nibble per RUN cycle,
    // publish the final carry on the last nibble. sum/carry are left alone
    // in IDLE and DONE so a result stays readable until the next RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            creg  <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa  <= a;
                        opb  <= b;
                        creg <= seed;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sum  <= sum_nxt;
                    opa  <= opa >> SLICE_W;
                    opb  <= opb >> SLICE_W;
                    creg <= slice_co;
                    if (last) begin
                        carry <= slice_co;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH = 16): directed vector
// table, backpressure / reset / back-to-back sequences, and random operands
// checked against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int LIM = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin_v = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
        .cin       (cin_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] esum;
        logic         ecarry;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: the whole-word sum, carry as bit W.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Wait for in_ready, present operands for one accept edge, then count
    // cycles until out_valid (LIM means it never came).
    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < LIM) begin
            @(posedge clk); #1;
            guard++;
        end
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LIM) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W:0] exp;
        logic [W-1:0] hold_s;
        logic hold_c;
        int acc_t[$];
        logic [W:0] res_q[$];
        logic [W:0] exp_q[$];

        vecs[0] = '{"simple",    16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
        vecs[1] = '{"ripple",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"cc_aa",     16'hCCCC, 16'hAAAA, 1'b0, 16'h7776, 1'b1};
        vecs[3] = '{"1234_1111", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[4] = '{"zero",      16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{"max_max",   16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
        vecs[6] = '{"alt_8_7",   16'h8888, 16'h7777, 1'b0, 16'hFFFF, 1'b0};
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
        vecs[7] = '{"cin_7fff",  16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1};
`else
        vecs[7] = '{"cin_7fff",  16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0};
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_in_ready_hi", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_lo", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            cin_v = vecs[i].vc;
            launch(vecs[i].va, vecs[i].vb, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(NIB));
            chk({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].esum));
            chk({vecs[i].name, "_carry"}, 32'(carry), 32'(vecs[i].ecarry));
            chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd0);
            release_out();
            chk({vecs[i].name, "_drop"}, 32'(out_valid), 32'd0);
        end
        cin_v = 1'b0;

        // Backpressure: result held for 3 cycles, stray in_valid ignored.
        launch(16'h0F0F, 16'h0101, lat);
        chk("bp_lat", 32'(lat), 32'(NIB));
        hold_s = sum;
        hold_c = carry;
        chk("bp_sum", 32'(hold_s), 32'h1010);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 16'h5555;
            b = 16'h5555;
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'(hold_s));
            chk("bp_hold_carry", 32'(carry), 32'(hold_c));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_sum", 32'(sum), 32'(hold_s));
        // Nothing was queued from the ignored in_valid.
        for (int k = 0; k < NIB + 2; k++) begin
            @(posedge clk); #1;
            chk("bp_no_ghost", 32'(out_valid), 32'd0);
        end

        // Reset after two RUN nibbles.
        a = 16'hFFFF;
        b = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_carry", 32'(carry), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < NIB + 2; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        launch(16'h1234, 16'h1111, lat);
        chk("post_rst_lat", 32'(lat), 32'(NIB));
        chk("post_rst_sum", 32'(sum), 32'h2345);
        chk("post_rst_carry", 32'(carry), 32'd0);
        release_out();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'hABCD;
        b = 16'h6543;
        exp_q.push_back(ref_add(16'hABCD, 16'h6543, 1'b0));
        exp_q.push_back(ref_add(16'h0F0F, 16'hF0F1, 1'b0));
        for (int t = 0; t < 30; t++) begin
            logic acc;
            acc = in_ready && in_valid;
            if (out_valid) res_q.push_back({carry, sum});
            @(posedge clk); #1;
            if (acc) begin
                acc_t.push_back(t);
                if (acc_t.size() == 1) begin
                    a = 16'h0F0F;
                    b = 16'hF0F1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_t.size()), 32'd2);
        chk("b2b_results", 32'(res_q.size()), 32'd2);
        if (acc_t.size() == 2)
            chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'(NIB + 2));
        for (int i = 0; i < 2; i++) begin
            if (i < res_q.size())
                chk("b2b_value", 32'(res_q[i]), 32'(exp_q[i]));
        end

        // Random operands against the reference, with random DONE hold time.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int hold;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
            cin_v = 1'($urandom_range(0, 1));
`endif
            exp = ref_add(ra, rb, cin_v);
            launch(ra, rb, lat);
            chk("rnd_lat", 32'(lat), 32'(NIB));
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
            end
            chk("rnd_sum", 32'(sum), 32'(exp[W-1:0]));
            chk("rnd_carry", 32'(carry), 32'(exp[W]));
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide adder that computes a WIDTH-bit sum four bits per cycle through a single 4-bit ripple-carry slice, carrying between nibbles in a register. It sits upstream of the datapath's result consumers and trades latency for area relative to a full-width ripple chain. Operands arrive on a valid/ready input handshake, and the result leaves on a valid/ready output handshake.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a and b are valid
- in_ready  output  1  block accepts operands; high only in IDLE with rst low
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; present only with NIBBLE_SERIAL_ADDER_CIN_EN
- out_valid  output  1  sum and carry hold a finished result
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  a + b (+ cin), modulo 2^WIDTH
- carry  output  1  carry out of bit WIDTH-1

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE and clears sum, carry, the carry register, the nibble counter and the operand registers.
- **IDLE.** in_ready = 1.
  - On in_valid: capture a and b into operand shift registers.
  - Set the carry register to cin, or to 0 without the macro.
  - Clear the counter and go to RUN.
- **RUN.** in_ready = 0. Every cycle:
  - Add the low nibble of A, the low nibble of B and the carry register in the slice.
  - Shift the 4-bit slice sum into sum from the MSB end (sum >> 4, with the slice sum placed in bits [WIDTH-1:WIDTH-4]).
  - Shift both operands right by 4.
  - Load the slice carry-out into the carry register.
  - Increment the counter. After NIB nibbles, copy the carry register to carry and go to DONE.
- **DONE.** out_valid = 1 and sum/carry are frozen. On out_ready go to IDLE, where out_valid drops. sum and carry keep their values until the next RUN begins.
- Boundary and corner behaviour:
  - in_valid outside IDLE is ignored, with no buffering.
  - out_ready outside DONE is ignored.
  - rst in any state aborts the operation immediately; no out_valid is produced for the aborted operands.
  - The counter width is max(1, $clog2(NIB)). The terminal compare is against NIB-1, so there is no wrap.
  - WIDTH = 4 degenerates to a single RUN cycle.

## Timing
- Accept edge T, where in_valid && in_ready.
- RUN edges are T+1 … T+NIB. out_valid goes high after edge T+NIB.
- Latency from accept to out_valid is NIB cycles (4 for WIDTH = 16).
- With out_ready tied high, DONE lasts one cycle and IDLE one cycle, giving a throughput of one operation per NIB+2 cycles.
- All outputs are registered, except in_ready and out_valid, which decode state directly.

## Configuration
- NIBBLE_SERIAL_ADDER_CIN_EN:
  - Defined: the cin port exists and seeds the carry register at accept.
  - Undefined: the port is absent and the seed is 0. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE)
  - the constant SLICE_W = 4
  - a function computing NIB and counter width from WIDTH
- One sub-module, rca4_cin, instantiated once: a 4-bit ripple-carry adder with carry-in (ports a, b, cin, sum, carry), built from full-adder bit cells.

## Test plan
- **Simple add, no carry.** WIDTH = 16, a = 0x0001, b = 0x0002 → sum = 0x0003, carry = 0. out_valid rises exactly 4 cycles after the accept edge.
- **Full carry ripple.** a = 0xFFFF, b = 0x0001 → sum = 0x0000, carry = 1, with the carry rippling across all four nibbles. a = 0xCCCC, b = 0xAAAA → sum = 0x7776, carry = 1.
- **Output backpressure.** Hold out_ready low for 3 cycles in DONE. Expect out_valid, sum and carry to stay stable and in_ready to stay 0. A new in_valid during this time is not accepted.
- **Reset mid-RUN.** Assert rst after 2 nibbles. The next cycle shows out_valid = 0, sum = 0, carry = 0, and in_ready = 1 once rst is low. A fresh 0x1234 + 0x1111 then yields 0x2345.
- **Carry-in (macro defined).** a = 0x7FFF, b = 0x8000, cin = 1 → sum = 0x0000, carry = 1. With the macro undefined, the same a and b give 0xFFFF, carry = 0.
- **Back-to-back operations.** Two operations with in_valid and out_ready held high: accept edges are spaced NIB+2 = 6 cycles apart and both results are correct.
